mem_responder: RTL
==================

Name: mem_responder

Overview:
- Word-addressed unified instruction/data memory. It serves the multicycle CPU's memory bus: `adr`, `writedata`, `MemWrite` in; `readdata` out.
- It adds a request/ready handshake with configurable latency, so the control FSM can stall on slow memory.
- It also flags misaligned and out-of-range accesses, and provides a combinational debug read port for the board/testbench.

Parameters:
- DEPTH, 1024: number of 32-bit words; the valid byte address range is 0 .. 4*DEPTH-1.
- LATENCY, 2: cycles from request acceptance to the `ready` pulse; legal range 1..15.
- INIT_FILE, "": hex image loaded into the array at elaboration when non-empty; otherwise contents are undefined.

Ports:
- clk  input  1  clock; rising edge active.
- rst  input  1  asynchronous, active-low reset.
- req  input  1  access request; the requester holds it high until `ready`.
- MemWrite  input  1  1 = write, 0 = read; sampled when the request is accepted.
- adr  input  32  byte address; sampled when the request is accepted.
- writedata  input  32  store data; sampled when the request is accepted.
- readdata  output  32  read result; valid from the `ready` cycle and held until the next completed read.
- ready  output  1  one-cycle completion pulse.
- err  output  1  asserted together with `ready` when the completed access was misaligned or out of range.
- busy  output  1  high while a request is outstanding.
- dbg_adr  input  32  debug byte address; combinational read, ignores the handshake.
- dbg_data  output  32  word at `dbg_adr[31:2]`; 0 if out of range.

Behaviour:
- Reset (`rst` = 0, asynchronous):
  - FSM goes to IDLE; the latency counter clears to 0.
  - `ready` = 0, `err` = 0, `busy` = 0, `readdata` = 0.
  - Array contents are not altered.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `req` = 1, capture `adr`, `writedata` and `MemWrite` into internal registers and load counter = LATENCY-1.
  - Go to RESP if LATENCY = 1, otherwise to WAIT. `busy` = 1 from the next cycle.
- WAIT:
  - Decrement the counter each cycle; go to RESP when it reaches 1.
  - Total time from the acceptance edge to the `ready` cycle is exactly LATENCY cycles.
- RESP:
  - `ready` = 1 for exactly one cycle.
  - Next state is always IDLE; `busy` drops with `ready`.
- Minimum spacing: a new request is accepted no earlier than the cycle after `ready` (IDLE re-entry). Back-to-back accesses therefore cost LATENCY+1 cycles each.
- Inputs are ignored while `busy` = 1. Changes to `adr`, `writedata` or `MemWrite` after acceptance have no effect.
- `req` falling before `ready` does not cancel the access; it completes normally.
- Error checks, evaluated on the captured address:
  - Misaligned: `adr[1:0]` != 0.
  - Out of range: `adr[31:2]` >= DEPTH.
- On an error:
  - `err` = 1 with `ready`.
  - Writes do not modify the array.
  - Reads return `readdata` = 32'h0000_0000.
- Writes:
  - Committed at the clock edge that ends the RESP cycle (i.e. with `ready` high).
  - `readdata` is unchanged by writes.
- Reads:
  - `readdata` is registered on the edge entering RESP and holds until the next completed read.
- Read-after-write to the same word, issued after the write's `ready`, returns the new data.
- Debug port:
  - `dbg_data` shows array contents combinationally, including a write committed at the previous edge.
  - It has no effect on the FSM.
- Reset mid-operation: the outstanding access is dropped. A pending write is not committed, `ready` is not generated, and the FSM is in IDLE after reset release.
- `req` held high continuously: a new access is accepted every LATENCY+1 cycles. A requester must deassert `req` in the `ready` cycle to avoid a duplicate access.

Test Plan:
1. LATENCY=2, reset, write `adr`=0x0000_0010, `writedata`=0xDEAD_BEEF, `req` held -> `ready` pulse 2 cycles after acceptance, `err`=0; then `dbg_adr`=0x10 -> `dbg_data`=0xDEAD_BEEF.
2. Read `adr`=0x10 after test 1 -> `readdata`=0xDEAD_BEEF in the `ready` cycle; it stays held while a following write to 0x14 of 0x1234_5678 completes.
3. Misaligned write `adr`=0x0000_0012, data 0xFFFF_FFFF -> `ready`=1 with `err`=1; `dbg_data` at 0x10 still 0xDEAD_BEEF. Out-of-range read `adr`=4*DEPTH -> `err`=1, `readdata`=0.
4. Change `adr`/`writedata` and pulse `req` while `busy`=1 -> ignored; the original access completes with the original values; exactly one `ready` pulse.
5. Assert `rst`=0 one cycle after accepting a write of 0xCAFE_F00D to 0x20 -> `ready`/`busy`/`readdata` = 0 immediately; after release, `dbg_data`@0x20 is unchanged from its prior value.
6. LATENCY=1 build, `req` held high for 6 cycles of reads to 0x10 -> `ready` in cycles 2, 4, 6 (one access every 2 cycles), each with `readdata`=0xDEAD_BEEF.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed unified memory with a req/ready handshake of
// configurable latency, access-error flagging and a combinational debug read port.
`timescale 1ns/1ps
`default_nettype none

module mem_responder #(
   parameter int    DEPTH     = 1024,
   parameter int    LATENCY   = 2,
   parameter string INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        MemWrite,
   input  logic [31:0] adr,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        ready,
   output logic        err,
   output logic        busy,
   input  logic [31:0] dbg_adr,
   output logic [31:0] dbg_data
);

   localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] adr_q;
   logic [31:0] wdata_q;
   logic        we_q;
   logic [31:0] readdata_q;
   logic        ready_q;
   logic        err_q;
   logic        busy_q;

   logic [31:0] mem [DEPTH];

   // With LATENCY=1 the response is entered straight from IDLE, so the access
   // attributes come from the live inputs rather than the capture registers.
   logic [31:0] acc_adr;
   logic        acc_we;
   logic        acc_err;
   logic [31:0] acc_rdata;

   always_comb begin
      acc_adr   = (state_q == S_IDLE) ? adr      : adr_q;
      acc_we    = (state_q == S_IDLE) ? MemWrite : we_q;
      acc_err   = (acc_adr[1:0] != 2'b00) ||
                  ({2'b00, acc_adr[31:2]} >= 32'(DEPTH));
      acc_rdata = 32'h0000_0000;
      if (!acc_err) begin
         acc_rdata = mem[acc_adr[AW+1:2]];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         adr_q      <= 32'h0;
         wdata_q    <= 32'h0;
         we_q       <= 1'b0;
         readdata_q <= 32'h0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  adr_q   <= adr;
                  wdata_q <= writedata;
                  we_q    <= MemWrite;
                  cnt_q   <= CNT_INIT;
                  busy_q  <= 1'b1;
                  if (LATENCY == 1) begin
                     state_q <= S_RESP;
                     ready_q <= 1'b1;
                     err_q   <= acc_err;
                     if (!acc_we) begin
                        readdata_q <= acc_rdata;
                     end
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q <= S_RESP;
                  ready_q <= 1'b1;
                  err_q   <= acc_err;
                  if (!acc_we) begin
                     readdata_q <= acc_rdata;
                  end
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               err_q   <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               err_q   <= 1'b0;
            end
         endcase
      end
   end

   // Store commits on the edge that ends the response cycle; a reset during
   // the access returns the FSM to IDLE first, so nothing is written.
   always_ff @(posedge clk) begin
      if ((state_q == S_RESP) && we_q && !err_q) begin
         mem[adr_q[AW+1:2]] <= wdata_q;
      end
   end

   logic unused_dbg;
   assign unused_dbg = ^dbg_adr[1:0];

   always_comb begin
      dbg_data = 32'h0000_0000;
      if ({2'b00, dbg_adr[31:2]} < 32'(DEPTH)) begin
         dbg_data = mem[dbg_adr[AW+1:2]];
      end
   end

   assign readdata = readdata_q;
   assign ready    = ready_q;
   assign err      = err_q;
   assign busy     = busy_q;

endmodule

`default_nettype wire
